// File: rtl/prach_ditfft3_bf2.sv
// -----------------------------------------------------------------------------
// prach_ditfft3_bf2
//
// Final butterfly of a radix-3 DIT stage. The upstream stage delivers each
// triplet on three consecutive cycles: x0 (flagged by sync_in), s = x1 + x2
// and d = x2 - x1. This block forms
//    X0 = x0 + s
//    X1 = x0 - s/2 - j*c*d      (c = sqrt(3)/2, Q1.17)
//    X2 = x0 - s/2 + j*c*d
// and emits X0/X1/X2 on consecutive cycles, four cycles after the samples
// that opened each output slot. Every result is rounded half toward +inf
// and saturated to 18 bits.
//
// Ports
//    clk               rising-edge clock
//    rst_n             asynchronous active-low reset
//    din_dr / din_di   signed 18-bit input sample (real / imag)
//    din_dv            input valid, carried alongside the data
//    sync_in           marks the x0 sample of a triplet
//    dout_dr / dout_di signed 18-bit result (real / imag)
//    dout_dv           din_dv delayed by 4 cycles
//    sync_out          sync_in delayed by 4 cycles (marks X0)
//
// Triplet phase FSM
//    state   | meaning
//    PH_IDLE | no triplet in progress, next non-sync sample is ignored
//    PH_S    | x0 seen last cycle, current sample is s
//    PH_D    | s seen last cycle, current sample is d
//    sync_in forces PH_S on the next cycle from any state, which abandons
//    any partially received triplet.
// -----------------------------------------------------------------------------
module prach_ditfft3_bf2 (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [17:0] din_dr,
   input  logic signed [17:0] din_di,
   input  logic               din_dv,
   input  logic               sync_in,
   output logic signed [17:0] dout_dr,
   output logic signed [17:0] dout_di,
   output logic               dout_dv,
   output logic               sync_out
);

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_S    = 2'd1,
      PH_D    = 2'd2
   } phase_t;

   // Role of the sample currently on din, as seen by the phase FSM.
   typedef enum logic [1:0] {
      ROLE_NONE = 2'd0,
      ROLE_X0   = 2'd1,
      ROLE_S    = 2'd2,
      ROLE_D    = 2'd3
   } role_t;

   localparam logic signed [36:0] C_SQ3    = 37'sd113512;
   localparam logic signed [39:0] RND_HALF = 40'sd65536;
   localparam logic signed [39:0] SAT_MAX  = 40'sd131071;
   localparam logic signed [39:0] SAT_MIN  = -40'sd131072;

   function automatic logic signed [17:0] sat18(input logic signed [39:0] v);
      if (v > SAT_MAX)
         sat18 = 18'sh1FFFF;
      else if (v < SAT_MIN)
         sat18 = 18'sh20000;
      else
         sat18 = v[17:0];
   endfunction

   // Q.17 accumulator back to integer: add half an LSB, floor by arithmetic shift.
   function automatic logic signed [17:0] rnd_sat(input logic signed [39:0] t);
      logic signed [39:0] r;
      r = (t + RND_HALF) >>> 17;
      rnd_sat = sat18(r);
   endfunction

   // ---------------------------------------------------------------- phase FSM
   phase_t phase_q;
   phase_t phase_d;
   role_t  role;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         phase_q <= PH_IDLE;
      else
         phase_q <= phase_d;
   end

   always_comb begin
      phase_d = PH_IDLE;
      if (sync_in) begin
         phase_d = PH_S;
      end else begin
         case (phase_q)
            PH_S:    phase_d = PH_D;
            default: phase_d = PH_IDLE;
         endcase
      end
   end

   always_comb begin
      role = ROLE_NONE;
      if (sync_in)
         role = ROLE_X0;
      else if (phase_q == PH_S)
         role = ROLE_S;
      else if (phase_q == PH_D)
         role = ROLE_D;
   end

   // ------------------------------------------------------- sample capture
   logic signed [17:0] x0r_q, x0i_q;
   logic signed [17:0] sr_q,  si_q;
   logic signed [17:0] dr_q,  di_q;
   role_t              role_q1, role_q2, role_q3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0r_q   <= '0;
         x0i_q   <= '0;
         sr_q    <= '0;
         si_q    <= '0;
         dr_q    <= '0;
         di_q    <= '0;
         role_q1 <= ROLE_NONE;
         role_q2 <= ROLE_NONE;
         role_q3 <= ROLE_NONE;
      end else begin
         if (role == ROLE_X0) begin
            x0r_q <= din_dr;
            x0i_q <= din_di;
         end
         if (role == ROLE_S) begin
            sr_q <= din_dr;
            si_q <= din_di;
         end
         if (role == ROLE_D) begin
            dr_q <= din_dr;
            di_q <= din_di;
         end
         role_q1 <= role;
         role_q2 <= role_q1;
         role_q3 <= role_q2;
      end
   end

   // ------------------------------------------- products and common term
   // role_q3 == ROLE_X0 is the cycle in which x0_q/s_q of that triplet are
   // both valid and not yet overwritten by a following back-to-back triplet.
   // The common term is frozen there for the X1 and X2 slots that follow.
   // The products run freely: d_q only changes on a d sample, so the product
   // register holds c*d for both X1 and X2 slots.
   logic signed [36:0] pr_q, pi_q;
   logic signed [36:0] pr_d, pi_d;
   logic signed [39:0] base_r_q, base_i_q;
   logic signed [39:0] base_r_d, base_i_d;

   always_comb begin
      pr_d     = C_SQ3 * 37'(dr_q);
      pi_d     = C_SQ3 * 37'(di_q);
      base_r_d = (40'(x0r_q) <<< 17) - (40'(sr_q) <<< 16);
      base_i_d = (40'(x0i_q) <<< 17) - (40'(si_q) <<< 16);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_q     <= '0;
         pi_q     <= '0;
         base_r_q <= '0;
         base_i_q <= '0;
      end else begin
         pr_q <= pr_d;
         pi_q <= pi_d;
         if (role_q3 == ROLE_X0) begin
            base_r_q <= base_r_d;
            base_i_q <= base_i_d;
         end
      end
   end

   // ------------------------------------------------------- output slot mux
   logic signed [39:0] sum_r, sum_i;
   logic signed [39:0] t1_r, t1_i, t2_r, t2_i;
   logic signed [17:0] dout_r_q, dout_i_q;
   logic signed [17:0] dout_r_d, dout_i_d;

   always_comb begin
      sum_r = 40'(x0r_q) + 40'(sr_q);
      sum_i = 40'(x0i_q) + 40'(si_q);
      t1_r  = base_r_q - 40'(pi_q);
      t1_i  = base_i_q + 40'(pr_q);
      t2_r  = base_r_q + 40'(pi_q);
      t2_i  = base_i_q - 40'(pr_q);
      dout_r_d = '0;
      dout_i_d = '0;
      case (role_q3)
         ROLE_X0: begin
            dout_r_d = sat18(sum_r);
            dout_i_d = sat18(sum_i);
         end
         ROLE_S: begin
            dout_r_d = rnd_sat(t1_r);
            dout_i_d = rnd_sat(t1_i);
         end
         ROLE_D: begin
            dout_r_d = rnd_sat(t2_r);
            dout_i_d = rnd_sat(t2_i);
         end
         default: begin
            dout_r_d = '0;
            dout_i_d = '0;
         end
      endcase
   end

   // --------------------------------------------------- dv / sync delay line
   logic [3:0] dv_q;
   logic [2:0] sync_q;
   logic       sync_out_q;
   logic       sync_out_d;

   // A sync immediately followed by another sync never receives its s sample,
   // so its X0 slot carries no result; that marker is dropped and only the
   // restarted triplet is flagged.
   always_comb begin
      sync_out_d = sync_q[2] & ~sync_q[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q       <= '0;
         sync_q     <= '0;
         sync_out_q <= 1'b0;
         dout_r_q   <= '0;
         dout_i_q   <= '0;
      end else begin
         dv_q       <= {dv_q[2:0], din_dv};
         sync_q     <= {sync_q[1:0], sync_in};
         sync_out_q <= sync_out_d;
         dout_r_q   <= dout_r_d;
         dout_i_q   <= dout_i_d;
      end
   end

   assign dout_dr  = dout_r_q;
   assign dout_di  = dout_i_q;
   assign dout_dv  = dv_q[3];
   assign sync_out = sync_out_q;

endmodule

// File: tb/tb_prach_ditfft3_bf2.sv
// -----------------------------------------------------------------------------
// Bench for prach_ditfft3_bf2. Every cycle's outputs are logged (index =
// cycle in which they are visible), and each scenario task checks the log
// against hand-computed values or a small reference model.
// -----------------------------------------------------------------------------
module tb_prach_ditfft3_bf2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [17:0] din_dr, din_di;
   logic               din_dv, sync_in;
   logic signed [17:0] dout_dr, dout_di;
   logic               dout_dv, sync_out;

   always #5 clk = ~clk;

   prach_ditfft3_bf2 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din_dr   (din_dr),
      .din_di   (din_di),
      .din_dv   (din_dv),
      .sync_in  (sync_in),
      .dout_dr  (dout_dr),
      .dout_di  (dout_di),
      .dout_dv  (dout_dv),
      .sync_out (sync_out)
   );

   localparam int  LOGN = 1024;
   localparam longint K = 113512;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic signed [17:0] lg_r  [LOGN];
   logic signed [17:0] lg_i  [LOGN];
   logic               lg_dv [LOGN];
   logic               lg_sy [LOGN];
   logic               in_dv [LOGN];
   logic               in_sy [LOGN];

   // Log the outputs of the current cycle, apply this cycle's inputs, advance.
   task automatic tick(input int r, input int i, input logic dv, input logic sy);
      if (cyc >= LOGN - 1) begin
         $display("FAIL log_overflow cyc=%0d limit=%0d", cyc, LOGN - 1);
         $fatal(1);
      end
      lg_r[cyc]  = dout_dr;
      lg_i[cyc]  = dout_di;
      lg_dv[cyc] = dout_dv;
      lg_sy[cyc] = sync_out;
      din_dr  = 18'(r);
      din_di  = 18'(i);
      din_dv  = dv;
      sync_in = sy;
      in_dv[cyc] = dv;
      in_sy[cyc] = sy;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic signed [17:0] ref_sat(input longint v);
      if (v > 131071)
         return 18'h1FFFF;
      if (v < -131072)
         return 18'h20000;
      return 18'(v);
   endfunction

   function automatic logic signed [17:0] ref_rnd(input longint t);
      return ref_sat((t + 64'sd65536) >>> 17);
   endfunction

   function automatic int rnd18();
      logic signed [17:0] v;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)
         return 131071;
      if (sel == 1)
         return -131072;
      v = 18'($urandom);
      return int'(v);
   endfunction

   // -------------------------------------------------------------------------
   task automatic test_reset();
      rst_n   = 1'b0;
      din_dr  = 18'sd1234;
      din_di  = -18'sd5;
      din_dv  = 1'b1;
      sync_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (dout_dr !== 18'sd0) begin fails++; $display("FAIL rst_dout_dr got %0d exp 0", dout_dr); end
      tests++; if (dout_di !== 18'sd0) begin fails++; $display("FAIL rst_dout_di got %0d exp 0", dout_di); end
      tests++; if (dout_dv !== 1'b0)   begin fails++; $display("FAIL rst_dout_dv got %b exp 0", dout_dv); end
      tests++; if (sync_out !== 1'b0)  begin fails++; $display("FAIL rst_sync_out got %b exp 0", sync_out); end
      rst_n = 1'b1;
      begin
         int c0;
         c0 = cyc;
         repeat (8) tick(0, 0, 1'b0, 1'b0);
         for (int c = c0; c < c0 + 8; c++) begin
            tests++; if (lg_dv[c] !== 1'b0) begin fails++; $display("FAIL post_rst_dv cyc%0d got %b exp 0", c - c0, lg_dv[c]); end
            tests++; if (lg_sy[c] !== 1'b0) begin fails++; $display("FAIL post_rst_sync cyc%0d got %b exp 0", c - c0, lg_sy[c]); end
         end
      end
   endtask

   // -------------------------------------------------------------------------
   // Directed vectors sent back-to-back: {x0r,x0i,sr,si,dr,di} -> {X0,X1,X2}.
   task automatic test_vectors();
      int vin [6][6];
      int vex [6][6];
      int t0;
      vin = '{'{1000, 0, 2000, 0, 0, 0},
              '{0, 0, 0, 0, 0, 1000},
              '{0, 0, 0, 0, 1000, 0},
              '{131071, -131072, 131071, -131072, 0, 0},
              '{0, 0, 1, 0, 0, 0},
              '{-131072, 131071, 131071, -131072, 131071, 131071}};
      vex = '{'{3000, 0, 0, 0, 0, 0},
              '{0, 0, -866, 0, 866, 0},
              '{0, 0, 0, 866, 0, -866},
              '{131071, -131072, 65536, -65536, 65536, -65536},
              '{1, 0, 0, 0, 0, 0},
              '{-1, -1, -131072, 131071, -83096, 83096}};
      t0 = cyc;
      for (int v = 0; v < 6; v++) begin
         tick(vin[v][0], vin[v][1], 1'b1, 1'b1);
         tick(vin[v][2], vin[v][3], 1'b1, 1'b0);
         tick(vin[v][4], vin[v][5], 1'b1, 1'b0);
      end
      repeat (7) tick(0, 0, 1'b0, 1'b0);
      tests++; if (lg_dv[t0 + 3] !== 1'b0) begin fails++; $display("FAIL vec_latency_dv got %b exp 0", lg_dv[t0 + 3]); end
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 3; k++) begin
            int c;
            c = t0 + 3 * v + 4 + k;
            tests++; if (lg_r[c] !== 18'(vex[v][2 * k])) begin fails++; $display("FAIL vec%0d_X%0d_re got %0d exp %0d", v, k, lg_r[c], vex[v][2 * k]); end
            tests++; if (lg_i[c] !== 18'(vex[v][2 * k + 1])) begin fails++; $display("FAIL vec%0d_X%0d_im got %0d exp %0d", v, k, lg_i[c], vex[v][2 * k + 1]); end
            tests++; if (lg_dv[c] !== 1'b1) begin fails++; $display("FAIL vec%0d_X%0d_dv got %b exp 1", v, k, lg_dv[c]); end
            tests++; if (lg_sy[c] !== (k == 0)) begin fails++; $display("FAIL vec%0d_X%0d_sync got %b exp %b", v, k, lg_sy[c], (k == 0)); end
         end
      end
      tests++; if (lg_dv[t0 + 22] !== 1'b0) begin fails++; $display("FAIL vec_tail_dv got %b exp 0", lg_dv[t0 + 22]); end
   endtask

   // -------------------------------------------------------------------------
   // sync at t and again at t+1: only the second triplet is reported.
   task automatic test_restart();
      int t;
      t = cyc;
      tick(5, 5, 1'b1, 1'b1);
      tick(100, 0, 1'b1, 1'b1);
      tick(50, 0, 1'b1, 1'b0);
      tick(0, 1000, 1'b1, 1'b0);
      repeat (8) tick(0, 0, 1'b0, 1'b0);
      for (int c = t; c < t + 10; c++) begin
         tests++; if (lg_sy[c] !== (c == t + 5)) begin fails++; $display("FAIL restart_sync cyc%0d got %b exp %b", c - t, lg_sy[c], (c == t + 5)); end
         tests++; if (lg_dv[c] !== (c >= t + 4 && c <= t + 7)) begin fails++; $display("FAIL restart_dv cyc%0d got %b exp %b", c - t, lg_dv[c], (c >= t + 4 && c <= t + 7)); end
      end
      tests++; if (lg_r[t + 5] !== 18'sd150) begin fails++; $display("FAIL restart_X0_re got %0d exp 150", lg_r[t + 5]); end
      tests++; if (lg_i[t + 5] !== 18'sd0)   begin fails++; $display("FAIL restart_X0_im got %0d exp 0", lg_i[t + 5]); end
      tests++; if (lg_r[t + 6] !== -18'sd791) begin fails++; $display("FAIL restart_X1_re got %0d exp -791", lg_r[t + 6]); end
      tests++; if (lg_i[t + 6] !== 18'sd0)   begin fails++; $display("FAIL restart_X1_im got %0d exp 0", lg_i[t + 6]); end
      tests++; if (lg_r[t + 7] !== 18'sd941) begin fails++; $display("FAIL restart_X2_re got %0d exp 941", lg_r[t + 7]); end
      tests++; if (lg_i[t + 7] !== 18'sd0)   begin fails++; $display("FAIL restart_X2_im got %0d exp 0", lg_i[t + 7]); end
   endtask

   // -------------------------------------------------------------------------
   // Reset pulse during the d sample of a triplet with dv=1.
   task automatic test_reset_mid();
      int r0;
      int t1;
      tick(7, 7, 1'b1, 1'b1);
      tick(20, -20, 1'b1, 1'b0);
      din_dr  = 18'sd300;
      din_di  = 18'sd300;
      din_dv  = 1'b1;
      sync_in = 1'b0;
      rst_n   = 1'b0;
      #1;
      tests++; if (dout_dr !== 18'sd0) begin fails++; $display("FAIL rstmid_dout_dr got %0d exp 0", dout_dr); end
      tests++; if (dout_di !== 18'sd0) begin fails++; $display("FAIL rstmid_dout_di got %0d exp 0", dout_di); end
      tests++; if (dout_dv !== 1'b0)   begin fails++; $display("FAIL rstmid_dout_dv got %b exp 0", dout_dv); end
      tests++; if (sync_out !== 1'b0)  begin fails++; $display("FAIL rstmid_sync_out got %b exp 0", sync_out); end
      r0 = cyc;
      tick(300, 300, 1'b1, 1'b0);
      tick(0, 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (6) tick(0, 0, 1'b0, 1'b0);
      t1 = cyc;
      tick(1000, 0, 1'b1, 1'b1);
      tick(2000, 0, 1'b1, 1'b0);
      tick(0, 1000, 1'b1, 1'b0);
      repeat (7) tick(0, 0, 1'b0, 1'b0);
      for (int c = r0; c < r0 + 2; c++) begin
         tests++; if (lg_r[c] !== 18'sd0) begin fails++; $display("FAIL rstmid_hold_re cyc%0d got %0d exp 0", c - r0, lg_r[c]); end
         tests++; if (lg_i[c] !== 18'sd0) begin fails++; $display("FAIL rstmid_hold_im cyc%0d got %0d exp 0", c - r0, lg_i[c]); end
      end
      for (int c = r0; c < t1 + 4; c++) begin
         tests++; if (lg_dv[c] !== 1'b0) begin fails++; $display("FAIL rstmid_quiet_dv cyc%0d got %b exp 0", c - r0, lg_dv[c]); end
         tests++; if (lg_sy[c] !== 1'b0) begin fails++; $display("FAIL rstmid_quiet_sync cyc%0d got %b exp 0", c - r0, lg_sy[c]); end
      end
      tests++; if (lg_sy[t1 + 4] !== 1'b1)   begin fails++; $display("FAIL rstmid_new_sync got %b exp 1", lg_sy[t1 + 4]); end
      tests++; if (lg_dv[t1 + 4] !== 1'b1)   begin fails++; $display("FAIL rstmid_new_dv got %b exp 1", lg_dv[t1 + 4]); end
      tests++; if (lg_r[t1 + 4] !== 18'sd3000) begin fails++; $display("FAIL rstmid_X0_re got %0d exp 3000", lg_r[t1 + 4]); end
      tests++; if (lg_r[t1 + 5] !== -18'sd866) begin fails++; $display("FAIL rstmid_X1_re got %0d exp -866", lg_r[t1 + 5]); end
      tests++; if (lg_r[t1 + 6] !== 18'sd866)  begin fails++; $display("FAIL rstmid_X2_re got %0d exp 866", lg_r[t1 + 6]); end
      tests++; if (lg_i[t1 + 6] !== 18'sd0)    begin fails++; $display("FAIL rstmid_X2_im got %0d exp 0", lg_i[t1 + 6]); end
   endtask

   // -------------------------------------------------------------------------
   // Random triplets, random idle gaps and random dv, against a reference model.
   task automatic test_random();
      localparam int NT = 40;
      int                 t0s [NT];
      logic signed [17:0] er  [NT][3];
      logic signed [17:0] ei  [NT][3];
      int                 start;
      start = cyc;
      for (int n = 0; n < NT; n++) begin
         int x0r, x0i, sr, si, dr, di, gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++)
            tick(rnd18(), rnd18(), 1'($urandom_range(0, 1)), 1'b0);
         x0r = rnd18(); x0i = rnd18();
         sr  = rnd18(); si  = rnd18();
         dr  = rnd18(); di  = rnd18();
         er[n][0] = ref_sat(longint'(x0r) + longint'(sr));
         ei[n][0] = ref_sat(longint'(x0i) + longint'(si));
         er[n][1] = ref_rnd((longint'(x0r) <<< 17) - (longint'(sr) <<< 16) - K * longint'(di));
         ei[n][1] = ref_rnd((longint'(x0i) <<< 17) - (longint'(si) <<< 16) + K * longint'(dr));
         er[n][2] = ref_rnd((longint'(x0r) <<< 17) - (longint'(sr) <<< 16) + K * longint'(di));
         ei[n][2] = ref_rnd((longint'(x0i) <<< 17) - (longint'(si) <<< 16) - K * longint'(dr));
         t0s[n] = cyc;
         tick(x0r, x0i, 1'($urandom_range(0, 3) != 0), 1'b1);
         tick(sr, si, 1'($urandom_range(0, 3) != 0), 1'b0);
         tick(dr, di, 1'($urandom_range(0, 3) != 0), 1'b0);
      end
      repeat (8) tick(0, 0, 1'b0, 1'b0);
      for (int c = start; c < cyc - 4; c++) begin
         tests++; if (lg_dv[c + 4] !== in_dv[c]) begin fails++; $display("FAIL rand_dv cyc%0d got %b exp %b", c + 4, lg_dv[c + 4], in_dv[c]); end
         tests++; if (lg_sy[c + 4] !== in_sy[c]) begin fails++; $display("FAIL rand_sync cyc%0d got %b exp %b", c + 4, lg_sy[c + 4], in_sy[c]); end
      end
      for (int n = 0; n < NT; n++) begin
         for (int k = 0; k < 3; k++) begin
            tests++; if (lg_r[t0s[n] + 4 + k] !== er[n][k]) begin fails++; $display("FAIL rand_tri%0d_X%0d_re got %0d exp %0d", n, k, lg_r[t0s[n] + 4 + k], er[n][k]); end
            tests++; if (lg_i[t0s[n] + 4 + k] !== ei[n][k]) begin fails++; $display("FAIL rand_tri%0d_X%0d_im got %0d exp %0d", n, k, lg_i[t0s[n] + 4 + k], ei[n][k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_restart();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prach_ditfft3_bf2.md
PRACH_DITFFT3_BF2 -- requirements
Module: prach_ditfft3_bf2

Interface
REQ-001 SHALL have no parameters; all widths and constants are fixed.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports din_dr/din_di, input, 18 each, signed real/imag input sample.
REQ-005 SHALL have port din_dv, input, 1, input valid (carried alongside the data, not a handshake).
REQ-006 SHALL have port sync_in, input, 1, marks the x0 sample of a triplet.
REQ-007 SHALL have ports dout_dr/dout_di, output, 18 each, signed real/imag result.
REQ-008 SHALL have ports dout_dv and sync_out, output, 1 each, valid and sync aligned to dout.

Function
REQ-009 SHALL consume triplets from the upstream radix-3 stage on consecutive cycles: t = x0 (sync_in=1), t+1 = s (x1+x2), t+2 = d (x2-x1).
REQ-010 SHALL track the triplet phase with a counter: 0 = idle, 1 = expecting s, 2 = expecting d. sync_in forces phase 1 next cycle. Phase 1 goes to 2, and 2 goes to 0.
REQ-011 SHALL restart the triplet on sync_in in any phase, including mid-triplet; the partial triplet is abandoned.
REQ-012 SHALL use constant c = 113512 (sqrt(3)/2 in Q1.17).
REQ-013 SHALL compute X0r = x0r+sr and X0i = x0i+si, then saturate.
REQ-014 SHALL compute X1r from T = (x0r<<17) - (sr<<16) - c*di; X1i from T = (x0i<<17) - (si<<16) + c*dr.
REQ-015 SHALL compute X2r from T = (x0r<<17) - (sr<<16) + c*di; X2i from T = (x0i<<17) - (si<<16) - c*dr.
REQ-016 SHALL hold T at 38 bits signed or wider and produce the result as (T + 65536) >>> 17, i.e. round half toward +inf.
REQ-017 SHALL saturate every output to [-131072, 131071]; it SHALL never wrap.
REQ-018 SHALL output X0, X1, X2 on cycles t+4, t+5, t+6: fixed latency 4 from each input sample to its output slot.
REQ-019 SHALL drive dout_dv and sync_out as din_dv and sync_in delayed exactly 4 cycles.
REQ-020 SHALL keep the data pipeline free-running and ignore din_dv for computation; dout_dr/di are don't-care when dout_dv=0.
REQ-021 SHALL leave dout_dr/di don't-care in cycles not covered by a complete triplet (phase 0 with no sync), while keeping dv/sync delay exact.
REQ-022 SHALL register each c*d product at least once before summation; multiplier depth is otherwise free within the latency of 4.

Reset
REQ-023 SHALL, while rst_n=0, drive dout_dr=0, dout_di=0, dout_dv=0 and sync_out=0, and set the phase counter to 0.
REQ-024 SHALL clear the dv/sync delay line on reset, so no stale sync_out or dout_dv appears after release.
REQ-025 SHALL, after deassertion, produce no output until a new sync_in; the first sync_out follows that sync_in by 4 cycles.
REQ-026 SHALL discard an in-flight triplet when reset asserts mid-triplet.

Verification
REQ-027 SHALL cover: x0=(1000,0), s=(2000,0), d=(0,0) -> X0=(3000,0) at t+4, X1=(0,0) at t+5, X2=(0,0) at t+6.
REQ-028 SHALL cover: x0=0, s=0, d=(0,1000) -> X0=(0,0), X1=(-866,0), X2=(866,0). Also d=(1000,0) -> X1=(0,866), X2=(0,-866).
REQ-029 SHALL cover: x0=(131071,-131072), s=(131071,-131072), d=0 -> X0=(131071,-131072) saturated, X1=X2=(65536,-65536). Also s=(1,0), x0=0, d=0 -> X1r=0 (rounding check).
REQ-030 SHALL cover: sync_in at t, then sync_in again at t+1 with a full new triplet -> exactly one sync_out, at t+5, carrying the second triplet's results; the first triplet produces no valid X1/X2.
REQ-031 SHALL cover: rst_n pulsed low at t+2 of a triplet with dv=1 -> all outputs 0 during reset, no sync_out or dout_dv afterwards until a new sync_in, then correct results with latency 4.
REQ-032 SHALL cover: random back-to-back triplets with random dv gaps, compared against a bit-exact reference model of REQ-013..017, with dout_dv/sync_out equal to the inputs delayed 4.
